sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-client round-robin SRAM arbiter with hold-time preemption
//
// Purpose:
//   Shares one single-port SRAM between three clients. Clients raise req,
//   and the arbiter grants one owner at a time in round-robin order. Each
//   ownership is followed by a one-cycle dead bus (TURNAROUND). A long-running
//   owner is preempted after MAX_HOLD grant cycles, but only if another
//   client is waiting.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req[2:0]                   per-client request (0 blob_extraction, 1 blob_sorting, 2 tracking)
//   grant[2:0]                 registered one-hot (or zero) ownership
//   cN_address/wren/data_write per-client SRAM access, muxed through while owned
//   mem_address/wren/data_write SRAM side; all zero when nobody is granted
//   mem_data_read              SRAM read data in
//   data_read                  read data broadcast unregistered to every client
//   busy                       high whenever the FSM is not IDLE

module sram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  output logic [2:0]        grant,
  input  logic [ADDR_W-1:0] c0_address,
  input  logic [ADDR_W-1:0] c1_address,
  input  logic [ADDR_W-1:0] c2_address,
  input  logic              c0_wren,
  input  logic              c1_wren,
  input  logic              c2_wren,
  input  logic [DATA_W-1:0] c0_data_write,
  input  logic [DATA_W-1:0] c1_data_write,
  input  logic [DATA_W-1:0] c2_data_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data_write,
  input  logic [DATA_W-1:0] mem_data_read,
  output logic [DATA_W-1:0] data_read,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  // Preemption fires on the grant cycle whose counter value is MAX_HOLD-1,
  // so the owner keeps the bus for exactly MAX_HOLD cycles.
  localparam logic [15:0] HOLD_LIMIT = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);

  state_t      state_q;
  logic [2:0]  grant_q;
  logic [1:0]  owner_q;
  logic [1:0]  last_owner_q;
  logic [15:0] hold_q;

  logic [1:0]  pick_d;
  logic [2:0]  pick_onehot_d;
  logic        owner_req;
  logic        others_req;
  logic        preempt;

  // First requester found searching cyclically from last+1.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    idx     = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick_d        = rr_pick(req, last_owner_q);
  assign pick_onehot_d = 3'b001 << pick_d;
  assign owner_req     = |(req & grant_q);
  assign others_req    = |(req & ~grant_q);
  assign preempt       = (MAX_HOLD != 0) && (hold_q >= HOLD_LIMIT) && others_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 3'b000;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd2;
      hold_q       <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q <= pick_d;
            grant_q <= pick_onehot_d;
            hold_q  <= 16'd0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (hold_q != 16'hFFFF) begin
            hold_q <= hold_q + 16'd1;
          end
          // A release and a preemption in the same cycle fold into one exit.
          if (!owner_req || preempt) begin
            grant_q      <= 3'b000;
            last_owner_q <= owner_q;
            state_q      <= TURNAROUND;
          end
        end
        TURNAROUND: begin
          // The dead-bus cycle also serves as the arbitration point, with
          // last_owner already pointing at the departing client, so pending
          // requests see exactly one zero-grant cycle between owners.
          if (|req) begin
            owner_q <= pick_d;
            grant_q <= pick_onehot_d;
            hold_q  <= 16'd0;
            state_q <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= 3'b000;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Muxing on the registered grant means reset zeroes the SRAM controls
  // immediately, without waiting for a clock edge.
  always_comb begin
    mem_address    = '0;
    mem_wren       = 1'b0;
    mem_data_write = '0;
    case (grant_q)
      3'b001: begin
        mem_address    = c0_address;
        mem_wren       = c0_wren;
        mem_data_write = c0_data_write;
      end
      3'b010: begin
        mem_address    = c1_address;
        mem_wren       = c1_wren;
        mem_data_write = c1_data_write;
      end
      3'b100: begin
        mem_address    = c2_address;
        mem_wren       = c2_wren;
        mem_data_write = c2_data_write;
      end
      default: begin
        mem_address    = '0;
        mem_wren       = 1'b0;
        mem_data_write = '0;
      end
    endcase
  end

  assign grant     = grant_q;
  assign data_read = mem_data_read;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter

module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [17:0] c0a, c1a, c2a;
  logic        c0w, c1w, c2w;
  logic [31:0] c0d, c1d, c2d;

  logic [2:0]  grant, grant2;
  logic [17:0] mem_address, mem_address2;
  logic        mem_wren, mem_wren2;
  logic [31:0] mem_data_write, mem_data_write2;
  logic [31:0] mem_data_read, mem_data_read2;
  logic [31:0] data_read, data_read2;
  logic        busy, busy2;

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_model(input logic [17:0] a);
    sram_model = (a == 18'd200003) ? 32'h10102000 : {14'h0, a};
  endfunction

  assign mem_data_read  = sram_model(mem_address);
  assign mem_data_read2 = sram_model(mem_address2);

  sram_arbiter #(.ADDR_W(18), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .c0_address(c0a), .c1_address(c1a), .c2_address(c2a),
    .c0_wren(c0w), .c1_wren(c1w), .c2_wren(c2w),
    .c0_data_write(c0d), .c1_data_write(c1d), .c2_data_write(c2d),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_data_write(mem_data_write),
    .mem_data_read(mem_data_read), .data_read(data_read), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(18), .DATA_W(32), .MAX_HOLD(1024)) dut2 (
    .clk(clk), .reset(reset), .req(req), .grant(grant2),
    .c0_address(c0a), .c1_address(c1a), .c2_address(c2a),
    .c0_wren(c0w), .c1_wren(c1w), .c2_wren(c2w),
    .c0_data_write(c0d), .c1_data_write(c1d), .c2_data_write(c2d),
    .mem_address(mem_address2), .mem_wren(mem_wren2), .mem_data_write(mem_data_write2),
    .mem_data_read(mem_data_read2), .data_read(data_read2), .busy(busy2)
  );

  typedef struct {
    logic [2:0]  g;
    logic        b;
    logic [17:0] a;
    logic        w;
    logic [31:0] d;
    logic [31:0] rd;
    logic        chk2;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;

  // Push the expected outputs for the current cycle.
  task automatic chk(input string tag, input logic [2:0] eg, input logic eb, input logic c2);
    exp_t x;
    x.g = eg; x.b = eb; x.chk2 = c2; x.tag = tag;
    x.a = '0; x.w = 1'b0; x.d = '0;
    case (eg)
      3'b001: begin x.a = c0a; x.w = c0w; x.d = c0d; end
      3'b010: begin x.a = c1a; x.w = c1w; x.d = c1d; end
      3'b100: begin x.a = c2a; x.w = c2w; x.d = c2d; end
      default: begin x.a = '0; x.w = 1'b0; x.d = '0; end
    endcase
    x.rd = sram_model(x.a);
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] eg, input logic eb);
    chk(tag, eg, eb, 1'b0);
    tick();
  endtask

  // Monitor: compares whatever the DUT shows mid-cycle against the queue head.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      n_total++;
      if (grant === e.g && busy === e.b && mem_address === e.a && mem_wren === e.w &&
          mem_data_write === e.d && data_read === e.rd)
        n_pass++;
      else
        $display("FAIL %s t=%0t: got grant=%b busy=%b addr=%0d wren=%b wdata=%h rdata=%h; want grant=%b busy=%b addr=%0d wren=%b wdata=%h rdata=%h",
                 e.tag, $time, grant, busy, mem_address, mem_wren, mem_data_write, data_read,
                 e.g, e.b, e.a, e.w, e.d, e.rd);
      if (e.chk2) begin
        n_total++;
        if (grant2 === e.g && busy2 === e.b) n_pass++;
        else $display("FAIL %s_hold1024 t=%0t: got grant=%b busy=%b; want grant=%b busy=%b",
                      e.tag, $time, grant2, busy2, e.g, e.b);
      end
    end
  end

  initial begin
    reset = 1'b1; req = 3'b000;
    c0a = 18'd1; c1a = 18'd2; c2a = 18'd3;
    c0w = 1'b1;  c1w = 1'b0;  c2w = 1'b1;
    c0d = 32'hAAAA0001; c1d = 32'hBBBB0002; c2d = 32'hCCCC0003;
    repeat (2) @(posedge clk);
    #1;
    step("reset_state", 3'b000, 1'b0);
    reset = 1'b0;

    // All three request: client 0 first, then 1, then 2.
    req = 3'b111;
    step("rr_idle", 3'b000, 1'b0);
    step("rr_g0", 3'b001, 1'b1);
    req = 3'b110;
    step("rr_g0_drop", 3'b001, 1'b1);
    step("rr_ta0", 3'b000, 1'b1);
    req = 3'b100;
    step("rr_g1", 3'b010, 1'b1);
    step("rr_ta1", 3'b000, 1'b1);
    req = 3'b000;
    step("rr_g2", 3'b100, 1'b1);
    step("rr_ta2", 3'b000, 1'b1);
    step("rr_idle_end", 3'b000, 1'b0);

    // Preemption every 4 cycles alternating between clients 0 and 1.
    c1w = 1'b1;
    req = 3'b011;
    step("pre_idle", 3'b000, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step("pre_g0", 3'b001, 1'b1);
      step("pre_ta0", 3'b000, 1'b1);
      for (int i = 0; i < 4; i++) step("pre_g1", 3'b010, 1'b1);
      step("pre_ta1", 3'b000, 1'b1);
    end
    req = 3'b000;
    step("pre_g0_last", 3'b001, 1'b1);
    step("pre_ta_last", 3'b000, 1'b1);
    step("pre_idle_end", 3'b000, 1'b0);

    // Client 1 owns the bus; client 0 inputs wiggle without effect.
    c1a = 18'd200003; c1w = 1'b0;
    req = 3'b010;
    step("mux_idle", 3'b000, 1'b0);
    step("mux_g1", 3'b010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      c0a = 18'(i * 7 + 5);
      c0w = ~c0w;
      c0d = c0d + 32'h11;
      step("mux_c0_toggle", 3'b010, 1'b1);
    end
    req = 3'b000;
    step("mux_g1_drop", 3'b010, 1'b1);
    step("mux_ta", 3'b000, 1'b1);
    step("mux_idle_end", 3'b000, 1'b0);

    // Asynchronous reset while client 0 is writing.
    c0a = 18'd77; c0w = 1'b1; c0d = 32'hDEAD0077;
    req = 3'b001;
    step("ar_idle", 3'b000, 1'b0);
    step("ar_g0_write", 3'b001, 1'b1);
    reset = 1'b1;
    step("ar_async", 3'b000, 1'b0);
    step("ar_held", 3'b000, 1'b0);
    reset = 1'b0;
    req = 3'b000;
    step("ar_idle_end", 3'b000, 1'b0);

    // Lone requester is never preempted, regardless of MAX_HOLD.
    req = 3'b100;
    step("solo_idle", 3'b000, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      chk("solo_hold", 3'b100, 1'b1, 1'b1);
      tick();
    end
    req = 3'b000;
    step("solo_drop", 3'b100, 1'b1);
    step("solo_ta", 3'b000, 1'b1);
    step("solo_idle_end", 3'b000, 1'b0);

    // One-cycle pulse with no write.
    c0w = 1'b0;
    req = 3'b001;
    step("pulse_idle", 3'b000, 1'b0);
    req = 3'b000;
    step("pulse_g0", 3'b001, 1'b1);
    step("pulse_ta", 3'b000, 1'b1);
    step("pulse_idle_end", 3'b000, 1'b0);

    // Owner drops req on the very cycle preemption would fire.
    req = 3'b011;
    step("both_idle", 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) step("both_g1", 3'b010, 1'b1);
    req = 3'b001;
    step("both_g1_last", 3'b010, 1'b1);
    step("both_ta", 3'b000, 1'b1);
    req = 3'b000;
    step("both_g0", 3'b001, 1'b1);
    step("both_ta0", 3'b000, 1'b1);
    step("both_idle_end", 3'b000, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
